// File: rtl/data_sram_bridge.sv
// Bridge from the mem stage's single-cycle load/store requests to the data-side
// sram-like bus (req/addr_ok/data_ok), with pipeline stall and flush draining.
module data_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_read_enable_i,
  input  logic [31:0] ram_read_addr_i,
  input  logic        ram_write_enable_i,
  input  logic [3:0]  ram_write_select_i,
  input  logic [31:0] ram_write_addr_i,
  input  logic [31:0] ram_write_data_i,
  input  logic        exception_i,
  input  logic        flush_i,
  input  logic        pipeline_stall_i,
  output logic [31:0] ram_read_data_o,
  output logic        stall_req_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        flush_pend;
  logic        rst_d;
  logic [31:0] rbuf;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        wr_valid, access_valid, quiet, issue;
  logic [1:0]  wsize, wlo;
  logic        legal_sel;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        complete, done_wr, discard;

  assign wr_valid     = ram_write_enable_i & (|ram_write_select_i);
  assign access_valid = (ram_read_enable_i | wr_valid) & ~exception_i;
  // Outputs stay silent while reset is held and for one cycle afterwards.
  assign quiet        = rst | rst_d;
  assign issue        = (state == S_IDLE) & access_valid & ~flush_i & ~quiet;
  assign state_dbg    = state;

  always_comb begin
    wsize     = 2'd2;
    wlo       = 2'd0;
    legal_sel = 1'b1;
    case (ram_write_select_i)
      4'b0001: begin wsize = 2'd0; wlo = 2'd0; end
      4'b0010: begin wsize = 2'd0; wlo = 2'd1; end
      4'b0100: begin wsize = 2'd0; wlo = 2'd2; end
      4'b1000: begin wsize = 2'd0; wlo = 2'd3; end
      4'b0011: begin wsize = 2'd1; wlo = 2'd0; end
      4'b1100: begin wsize = 2'd1; wlo = 2'd2; end
      4'b1111: begin wsize = 2'd2; wlo = 2'd0; end
      default: legal_sel = 1'b0;
    endcase
  end

  // A load wins when both enables are set.
  assign req_wr    = ~ram_read_enable_i;
  assign req_size  = ram_read_enable_i ? 2'd2 : wsize;
  assign req_addr  = ram_read_enable_i ? ram_read_addr_i
                                       : {ram_write_addr_i[31:2], ram_write_addr_i[1:0] | wlo};
  assign req_wdata = ram_read_enable_i ? 32'h0 : ram_write_data_i;

  always_comb begin
    state_nx        = state;
    data_req_o      = 1'b0;
    stall_req_o     = 1'b0;
    data_wr_o       = lat_wr;
    data_size_o     = lat_size;
    data_addr_o     = lat_addr;
    data_wdata_o    = lat_wdata;
    ram_read_data_o = 32'h0;
    complete        = 1'b0;
    done_wr         = lat_wr;
    discard         = flush_pend | flush_i;
    case (state)
      S_IDLE: begin
        stall_req_o  = access_valid;
        data_wr_o    = 1'b0;
        data_size_o  = 2'd0;
        data_addr_o  = 32'h0;
        data_wdata_o = 32'h0;
        discard      = 1'b0;
        if (issue) begin
          data_req_o   = 1'b1;
          data_wr_o    = req_wr;
          data_size_o  = req_size;
          data_addr_o  = req_addr;
          data_wdata_o = req_wdata;
          done_wr      = req_wr;
          if (data_addr_ok_i && data_data_ok_i) begin
            complete = 1'b1;
            state_nx = S_DONE;
          end else if (data_addr_ok_i) begin
            state_nx = S_WAIT;
          end else begin
            state_nx = S_REQ;
          end
        end
      end
      S_REQ: begin
        data_req_o  = 1'b1;
        stall_req_o = 1'b1;
        if (data_addr_ok_i && data_data_ok_i) begin
          complete = 1'b1;
          state_nx = discard ? S_IDLE : S_DONE;
        end else if (data_addr_ok_i) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_req_o = 1'b1;
        if (data_data_ok_i) begin
          complete = 1'b1;
          state_nx = discard ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        ram_read_data_o = rbuf;
        if (flush_i || !pipeline_stall_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (quiet) begin
      data_req_o      = 1'b0;
      stall_req_o     = 1'b0;
      data_wr_o       = 1'b0;
      data_size_o     = 2'd0;
      data_addr_o     = 32'h0;
      data_wdata_o    = 32'h0;
      ram_read_data_o = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      flush_pend <= 1'b0;
      rst_d      <= 1'b1;
      rbuf       <= 32'h0;
      lat_wr     <= 1'b0;
      lat_size   <= 2'd0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
    end else begin
      rst_d <= 1'b0;
      state <= state_nx;
      // Fields track the inputs in IDLE so REQ replays exactly what was first offered.
      if (state == S_IDLE) begin
        lat_wr    <= req_wr;
        lat_size  <= req_size;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (complete)
        flush_pend <= 1'b0;
      else if (flush_i && (state == S_REQ || state == S_WAIT))
        flush_pend <= 1'b1;
      if (complete)
        rbuf <= (done_wr || discard) ? 32'h0 : data_rdata_i;
    end
  end

  a_no_dual_access: assert property (@(posedge clk) disable iff (rst)
    !(ram_read_enable_i && ram_write_enable_i));
  a_legal_select: assert property (@(posedge clk) disable iff (rst)
    !(wr_valid && !ram_read_enable_i && !exception_i) || legal_sel);
  a_data_ok_order: assert property (@(posedge clk) disable iff (rst)
    (state == S_REQ) |-> !(data_data_ok_i && !data_addr_ok_i));

endmodule
